ram_sync_read_dp: RTL

Parameterised simple-dual-port synchronous-read RAM: one write port with byte enables, one independent read port with registered output and valid flag. On reset, an internal sequencer clears the whole array to a programmable value before accepting traffic. Used as the generic data/coefficient store between datapath stages, where single-address RAMs cannot serve simultaneous producer and consumer access.

---
 rtl/ram_sync_read_dp.sv | 112 +++++++++++
 1 files changed

// File: rtl/ram_sync_read_dp.sv
// Simple-dual-port RAM with a byte-enable write port and a registered read port.
// After reset it clears itself to INIT_VALUE. Define RAM_OUT_REG_EN to add a second output stage.
module ram_sync_read_dp #(
  parameter int                AWIDTH     = 3,
  parameter int                DWIDTH     = 32,
  parameter int                RDW_MODE   = 0,
  parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [AWIDTH-1:0]     wr_addr,
  input  logic [DWIDTH-1:0]     wr_din,
  input  logic [DWIDTH/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [AWIDTH-1:0]     rd_addr,
  output logic [DWIDTH-1:0]     rd_dout,
  output logic                  rd_valid,
  output logic                  init_busy
);

  localparam int              DEPTH     = 1 << AWIDTH;
  localparam int              NBYTES    = DWIDTH / 8;
  localparam logic [AWIDTH:0] LAST_ADDR = (AWIDTH + 1)'(DEPTH - 1);
  localparam logic [AWIDTH:0] CNT_ONE   = (AWIDTH + 1)'(1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_next;
  logic [AWIDTH:0]   clr_cnt, clr_cnt_next;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] wr_mask;
  logic [DWIDTH-1:0] rd_word;
  logic [DWIDTH-1:0] rd_data_q;
  logic              rd_valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // The clear counter is one bit wider than the address so it never wraps.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    case (state)
      CLEAR: begin
        clr_cnt_next = clr_cnt + CNT_ONE;
        if (clr_cnt == LAST_ADDR) state_next = READY;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < NBYTES; i++) wr_mask[8*i +: 8] = {8{wr_be[i]}};
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clr_cnt[AWIDTH-1:0]] <= INIT_VALUE;
      end else if (wr_en) begin
        for (int i = 0; i < NBYTES; i++)
          if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_din[8*i +: 8];
      end
    end
  end

  // Write-first mode forwards the enabled bytes of a colliding write.
  always_comb begin
    rd_word = mem[rd_addr];
    if (RDW_MODE == 1 && wr_en && wr_addr == rd_addr)
      rd_word = (rd_word & ~wr_mask) | (wr_din & wr_mask);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (state == READY) begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_word;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

`ifdef RAM_OUT_REG_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_dout  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_dout  <= rd_data_q;
      rd_valid <= rd_valid_q;
    end
  end
`else
  assign rd_dout  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif

  assign init_busy = (state == CLEAR);

endmodule
